// File: rtl/vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_gen: raster sync, draw-window, coordinate and strobe generator.
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          HDraw,
  output logic          VDraw,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_dw      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
  localparam logic [CW-1:0]   c_h_last   = CW'(c_h_total - 1);
  localparam logic [CW-1:0]   c_v_last   = CW'(c_v_total - 1);
  localparam logic [CW-1:0]   c_h_act    = CW'(H_ACTIVE);
  localparam logic [CW-1:0]   c_v_act    = CW'(V_ACTIVE);
  localparam logic [CW-1:0]   c_hs_start = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]   c_hs_end   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]   c_vs_start = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]   c_vs_end   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_dw-1:0] div_q, div_d;
  logic [CW-1:0]   h_q, h_d, v_q, v_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            hdraw_q, hdraw_d, vdraw_q, vdraw_d;
  logic            line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic            w_tick, w_h_wrap;

  always_comb begin
    w_tick   = (div_q == c_div_last);
    div_d    = w_tick ? '0 : div_q + c_dw'(1);
    w_h_wrap = (h_q == c_h_last);
    h_d      = h_q;
    v_d      = v_q;
    if (w_tick) begin
      h_d = w_h_wrap ? '0 : h_q + CW'(1);
      if (w_h_wrap) begin
        v_d = (v_q == c_v_last) ? '0 : v_q + CW'(1);
      end
    end
    // Flags decode the next position so they land on the same edge as x/y.
    hdraw_d       = (h_d < c_h_act);
    vdraw_d       = (v_d < c_v_act);
    hsync_d       = ((h_d >= c_hs_start) && (h_d < c_hs_end)) ? HS_POL : ~HS_POL;
    vsync_d       = ((v_d >= c_vs_start) && (v_d < c_vs_end)) ? VS_POL : ~VS_POL;
    line_start_d  = w_tick && (h_d == '0);
    frame_start_d = line_start_d && (v_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      h_q           <= c_h_last;
      v_q           <= c_v_last;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hdraw_q       <= 1'b0;
      vdraw_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hdraw_q       <= hdraw_d;
      vdraw_q       <= vdraw_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_ce      = w_tick & rst;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign HDraw       = hdraw_q;
  assign VDraw       = vdraw_q;
  assign x           = h_q;
  assign y           = v_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_timing_gen: directed checks of default, small-frame/pos-polarity and
// divided-clock raster generators. Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b0, rst_s = 1'b0, rst_q = 1'b0;

  logic        d_ce, d_hs, d_vs, d_hd, d_vd, d_ls, d_fs;
  logic [10:0] d_x, d_y;
  logic        s_ce, s_hs, s_vs, s_hd, s_vd, s_ls, s_fs;
  logic [4:0]  s_x, s_y;
  logic        q_ce, q_hs, q_vs, q_hd, q_vd, q_ls, q_fs;
  logic [10:0] q_x, q_y;

  vga_timing_gen u_d (
    .clk(clk), .rst(rst_d), .pix_ce(d_ce), .hsync(d_hs), .vsync(d_vs),
    .HDraw(d_hd), .VDraw(d_vd), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // Small frame: H_TOTAL=16 (sync x=10..12), V_TOTAL=10 (sync y=7..8), positive syncs.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
  ) u_s (
    .clk(clk), .rst(rst_s), .pix_ce(s_ce), .hsync(s_hs), .vsync(s_vs),
    .HDraw(s_hd), .VDraw(s_vd), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(.CLK_DIV(4)) u_q (
    .clk(clk), .rst(rst_q), .pix_ce(q_ce), .hsync(q_hs), .vsync(q_vs),
    .HDraw(q_hd), .VDraw(q_vd), .x(q_x), .y(q_y),
    .line_start(q_ls), .frame_start(q_fs)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int n;
    int x;
    int y;
    bit hd, vd, hs, vs, ls, fs;
  } vec_t;

  vec_t tab[11];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int cnt_a, cnt_b, cnt_c, cnt_d, cnt_e, err, last;
    logic [10:0] prev_x;
    bit found;

    // n = clk edges since reset release, sampled 1 time unit after the edge
    tab[0]  = '{1,   0,   0, 1, 1, 1, 1, 1, 1};
    tab[1]  = '{2,   1,   0, 1, 1, 1, 1, 0, 0};
    tab[2]  = '{640, 639, 0, 1, 1, 1, 1, 0, 0};
    tab[3]  = '{641, 640, 0, 0, 1, 1, 1, 0, 0};
    tab[4]  = '{656, 655, 0, 0, 1, 1, 1, 0, 0};
    tab[5]  = '{657, 656, 0, 0, 1, 0, 1, 0, 0};
    tab[6]  = '{752, 751, 0, 0, 1, 0, 1, 0, 0};
    tab[7]  = '{753, 752, 0, 0, 1, 1, 1, 0, 0};
    tab[8]  = '{800, 799, 0, 0, 1, 1, 1, 0, 0};
    tab[9]  = '{801, 0,   1, 1, 1, 1, 1, 1, 0};
    tab[10] = '{802, 1,   1, 1, 1, 1, 1, 0, 0};

    repeat (3) step();
    chk("d_reset_state", {d_x, d_y, d_hd, d_vd, d_hs, d_vs, d_ls, d_fs, d_ce},
        {11'd799, 11'd524, 7'b0011000});
    chk("q_reset_pix_ce", q_ce, 0);
    chk("s_reset_state", {s_x, s_y, s_hd, s_vd, s_hs, s_vs, s_ls, s_fs, s_ce},
        {5'd15, 5'd9, 7'b0000000});

    rst_d = 1'b1;
    n = 0;
    for (int i = 0; i < 11; i++) begin
      while (n < tab[i].n) begin
        step();
        n++;
      end
      chk($sformatf("vec%0d_n%0d", i, tab[i].n),
          {d_x, d_y, d_hd, d_vd, d_hs, d_vs, d_ls, d_fs},
          {11'(tab[i].x), 11'(tab[i].y), tab[i].hd, tab[i].vd,
           tab[i].hs, tab[i].vs, tab[i].ls, tab[i].fs});
    end

    // One full line starting at a line_start
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      found = d_ls;
    end
    chk("d_wait_line_start", found, 1);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; err = 0;
    for (int i = 0; i < 800; i++) begin
      if (d_hd) cnt_a++;
      if (!d_hs) cnt_b++;
      if (d_ls) cnt_c++;
      if (d_hs != !(d_x >= 656 && d_x <= 751)) err++;
      step();
    end
    chk("d_line_hdraw_cnt", cnt_a, 640);
    chk("d_line_hsync_low_cnt", cnt_b, 96);
    chk("d_line_hsync_window_err", err, 0);
    chk("d_line_start_cnt", cnt_c, 1);
    chk("d_line_period", {d_ls, d_x}, {1'b1, 11'd0});

    // Asynchronous reset mid-frame
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      if (d_x == 300 && d_y == 3) found = 1'b1;
      else step();
    end
    chk("d_wait_300_3", found, 1);
    #2 rst_d = 1'b0;
    #1;
    chk("d_async_reset", {d_x, d_y, d_hd, d_vd, d_hs, d_vs, d_ls, d_fs, d_ce},
        {11'd799, 11'd524, 7'b0011000});
    step();
    step();
    rst_d = 1'b1;
    step();
    chk("d_restart", {d_x, d_y, d_hd, d_vd, d_ls, d_fs},
        {11'd0, 11'd0, 4'b1111});

    // Small frame, positive syncs
    rst_s = 1'b1;
    step();
    chk("s_first", {s_x, s_y, s_fs, s_ls, s_hs, s_vs}, {5'd0, 5'd0, 4'b1100});
    cnt_a = 0; cnt_b = 0; cnt_c = 0; err = 0;
    for (int i = 0; i < 160; i++) begin
      if (s_vs) cnt_a++;
      if (s_hd && s_vd) cnt_b++;
      if (s_fs) cnt_c++;
      if (s_vs != (s_y >= 7 && s_y <= 8)) err++;
      if (s_hs != (s_x >= 10 && s_x <= 12)) err++;
      if (s_vd != (s_y < 6)) err++;
      if (s_hd != (s_x < 8)) err++;
      step();
    end
    chk("s_vsync_active_cnt", cnt_a, 32);
    chk("s_draw_cnt", cnt_b, 48);
    chk("s_frame_start_cnt", cnt_c, 1);
    chk("s_window_err", err, 0);
    chk("s_frame_period", {s_fs, s_x, s_y}, {1'b1, 5'd0, 5'd0});

    // Divided pixel clock
    rst_q = 1'b1;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      n++;
      found = q_fs;
    end
    chk("q_first_frame_edges", n, 4);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; cnt_e = 0; err = 0;
    last = -1;
    prev_x = q_x;
    for (int i = 0; i < 3200; i++) begin
      if (q_ce) begin
        cnt_a++;
        if (last >= 0 && i - last != 4) err++;
        last = i;
      end
      if (i > 0 && q_x != prev_x) cnt_b++;
      if (i > 0 && q_x != prev_x && i % 4 != 0) cnt_e++;
      prev_x = q_x;
      if (q_ls) cnt_c++;
      if (q_fs) cnt_d++;
      step();
    end
    chk("q_pix_ce_cnt", cnt_a, 800);
    chk("q_pix_ce_gap_err", err, 0);
    chk("q_x_steps", cnt_b, 799);
    chk("q_x_step_phase_err", cnt_e, 0);
    chk("q_line_start_cnt", cnt_c, 1);
    chk("q_frame_start_cnt", cnt_d, 1);
    chk("q_line_period", {q_ls, q_x, q_y}, {1'b1, 11'd0, 11'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA pipeline: it produces horizontal/vertical sync and the `HDraw`/`VDraw` draw-window levels that gate the image storage stage directly downstream. It also supplies pixel coordinates and line/frame start strobes. Default parameters give 640x480@60 Hz from a 25 MHz pixel rate. An optional clock-enable divider derives the pixel rate from a faster system clock.

## Interface
- `CLK_DIV`, 1: system clocks per pixel (>=1); 1 = one pixel per `clk`.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `HS_POL`, 0: hsync active level (0 = active-low).
- `VS_POL`, 0: vsync active level (0 = active-low).
- `CW`, 11: counter/coordinate width; 2^CW > max(H_TOTAL, V_TOTAL).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `pix_ce`  out  1  high on a `clk` cycle whose rising edge advances the raster position.
- `hsync`  out  1  horizontal sync, polarity per `HS_POL`.
- `vsync`  out  1  vertical sync, polarity per `VS_POL`.
- `HDraw`  out  1  high while the horizontal position is in the active region.
- `VDraw`  out  1  high while the vertical position is in the active region.
- `x`  out  CW  current horizontal count `h`.
- `y`  out  CW  current vertical count `v`.
- `line_start`  out  1  one-`clk` pulse when `h` becomes 0.
- `frame_start`  out  1  one-`clk` pulse when (`h`,`v`) becomes (0,0).

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider `div` counts 0..CLK_DIV-1 every `clk`, then wraps. Internal `tick` = (`div`==CLK_DIV-1). When CLK_DIV=1, `tick` is constantly 1.
- `pix_ce` = `tick` AND `rst` (forced 0 while in reset).
- On each edge with `tick`:
  - `h` <= (`h`==H_TOTAL-1) ? 0 : `h`+1.
  - When `h` wraps: `v` <= (`v`==V_TOTAL-1) ? 0 : `v`+1. Otherwise `v` holds.
- Regions, with `h` and `v` counted from 0:
  - Active: `h` < H_ACTIVE.
  - Front porch: H_ACTIVE <= `h` < H_ACTIVE+H_FP.
  - Sync: H_ACTIVE+H_FP <= `h` < H_ACTIVE+H_FP+H_SYNC (656..751).
  - Back porch: the remainder.
  - Vertical regions are the same with the V_* parameters; vsync covers `v` = 490..491.
- Output decodes:
  - `HDraw` = (`h` < H_ACTIVE); `VDraw` = (`v` < V_ACTIVE).
  - `hsync` = HS_POL while `h` is in the sync region, else ~HS_POL. `vsync` likewise with VS_POL.
- `x` = `h`, `y` = `v` at all times. Counts are unsigned modulo; no other arithmetic.
- Reset values (async, while `rst`=0):
  - `div`=0, `h`=H_TOTAL-1 (799), `v`=V_TOTAL-1 (524).
  - `HDraw`=`VDraw`=0; `hsync`=~HS_POL (1); `vsync`=~VS_POL (1).
  - `line_start`=`frame_start`=0, `pix_ce`=0.
  - The first tick after release wraps the raster to (0,0) and starts a frame.
- Reset asserted mid-frame: all state returns to the reset values immediately. No partial-frame completion is performed.

## Timing
- All outputs except `pix_ce` are registered. `hsync`, `vsync`, `HDraw`, `VDraw`, `x`, `y`, `line_start` and `frame_start` change on the same edge as `h`/`v`, decoded from next-state values. There is zero lag between `x`/`y` and the flags.
- `pix_ce` is combinational from `div` and `rst`. It is high in the cycle before the edge that advances the raster.
- `line_start` and `frame_start` are high for exactly one `clk` cycle, the first cycle of the new position, regardless of CLK_DIV. `frame_start` implies `line_start`.
- Draw levels persist for CLK_DIV clocks per pixel. The downstream consumer advances once per `clk` while `HDraw`&`VDraw` is high, so it is exactly pixel-aligned only when CLK_DIV=1.
- First edge after `rst` rises with CLK_DIV=1: (`x`,`y`)=(0,0), `HDraw`=`VDraw`=1, `line_start`=`frame_start`=1.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clocks (420000 with defaults).

## Test plan
- Reset release, CLK_DIV=1:
  - During reset: `x`=799, `y`=524, draw=0, syncs=1, `pix_ce`=0.
  - First edge after release: `x`=0, `y`=0, `HDraw`=`VDraw`=1, `frame_start`=1 for 1 cycle.
- One line, defaults:
  - `HDraw` high for 640 clocks, then low.
  - `hsync` low exactly for `x`=656..751 (96 clocks).
  - `line_start` pulses every 800 clocks.
- Full frame, defaults:
  - `vsync` low only for `y`=490..491 (1600 clocks).
  - `VDraw` high for `y`=0..479.
  - `frame_start` repeats every 420000 clocks.
  - Count of `HDraw`&`VDraw` cycles = 307200.
- CLK_DIV=4:
  - `pix_ce` high 1 of every 4 clocks.
  - `x` steps every 4 clocks.
  - `line_start`/`frame_start` still 1 clock wide.
  - Line period 3200 clocks.
- Polarity, HS_POL=1, VS_POL=1: syncs idle 0 (including during reset) and are high in the sync windows.
- `rst` pulsed low at `x`=300, `y`=200: outputs return to reset values asynchronously; after release the sequence restarts at (0,0) with `frame_start`.
